// File: rtl/dispatch_buffer.sv
// dispatch_buffer
//   Circular buffer between rename and the reservation stations. Rename
//   deposits up to DISP_WIDTH micro-ops per cycle as an all-or-nothing group.
//   Each entry carries its ROB index. The oldest ISSUE_WIDTH entries are
//   presented in program order, and a leading run of accepted lanes is
//   removed each cycle.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_uop   lane-packed rename group (valid lanes contiguous from 0)
//   in_ready          whole group can be accepted this cycle
//   rob_ready         ROB has room for a full group
//   rob_tail_idx      ROB index of lane 0 of this cycle's group
//   rob_alloc_valid   per-lane ROB allocation strobe (same cycle as accept)
//   out_valid/out_uop/out_rob_idx  oldest entries, lane 0 oldest
//   out_ready         per-lane reservation-station acceptance
//   flush             pipeline squash, empties the buffer at the next edge
//   occupancy         current entry count
module dispatch_buffer #(
  parameter int DISP_WIDTH  = 2,
  parameter int ISSUE_WIDTH = 2,
  parameter int DEPTH       = 16,
  parameter int UOP_W       = 64,
  parameter int ROB_IDX_W   = 6
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DISP_WIDTH-1:0]            in_valid,
  input  logic [DISP_WIDTH*UOP_W-1:0]      in_uop,
  output logic                             in_ready,
  input  logic                             rob_ready,
  input  logic [ROB_IDX_W-1:0]             rob_tail_idx,
  output logic [DISP_WIDTH-1:0]            rob_alloc_valid,
  output logic [ISSUE_WIDTH-1:0]           out_valid,
  output logic [ISSUE_WIDTH*UOP_W-1:0]     out_uop,
  output logic [ISSUE_WIDTH*ROB_IDX_W-1:0] out_rob_idx,
  input  logic [ISSUE_WIDTH-1:0]           out_ready,
  input  logic                             flush,
  output logic [$clog2(DEPTH):0]           occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]        head_q, head_d;
  logic [PW-1:0]        tail_q, tail_d;
  logic [CW-1:0]        occ_q, occ_d;
  logic [UOP_W-1:0]     uop_mem_q [DEPTH];
  logic [UOP_W-1:0]     uop_mem_d [DEPTH];
  logic [ROB_IDX_W-1:0] rob_mem_q [DEPTH];
  logic [ROB_IDX_W-1:0] rob_mem_d [DEPTH];

  logic [CW-1:0]        free_slots;
  logic [CW-1:0]        nenq;
  logic [CW-1:0]        ndeq;
  logic                 deq_run;

  // Accept side: the room check uses start-of-cycle occupancy only, so slots
  // being dequeued this cycle never enable an enqueue in the same cycle.
  always_comb begin
    free_slots      = CW'(DEPTH) - occ_q;
    in_ready        = !rst && !flush && rob_ready && (free_slots >= CW'(DISP_WIDTH));
    rob_alloc_valid = in_valid & {DISP_WIDTH{in_ready}};
    nenq            = '0;
    for (int i = 0; i < DISP_WIDTH; i++) begin
      if (rob_alloc_valid[i]) nenq = nenq + CW'(1);
    end
  end

  // Issue side: lane k shows slot head+k. Dequeue stops at the first lane
  // that is not both valid and ready; a flush cycle removes nothing.
  always_comb begin
    out_valid   = '0;
    out_uop     = '0;
    out_rob_idx = '0;
    ndeq        = '0;
    deq_run     = !flush;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      out_valid[k]                           = !rst && (CW'(k) < occ_q);
      out_uop[k*UOP_W +: UOP_W]              = uop_mem_q[head_q + PW'(k)];
      out_rob_idx[k*ROB_IDX_W +: ROB_IDX_W]  = rob_mem_q[head_q + PW'(k)];
      deq_run = deq_run & out_valid[k] & out_ready[k];
      if (deq_run) ndeq = ndeq + CW'(1);
    end
  end

  // Next state: pointers wrap naturally at PW bits since DEPTH is a power of two.
  always_comb begin
    head_d    = head_q + PW'(ndeq);
    tail_d    = tail_q + PW'(nenq);
    occ_d     = occ_q + nenq - ndeq;
    uop_mem_d = uop_mem_q;
    rob_mem_d = rob_mem_q;
    for (int i = 0; i < DISP_WIDTH; i++) begin
      if (rob_alloc_valid[i]) begin
        uop_mem_d[tail_q + PW'(i)] = in_uop[i*UOP_W +: UOP_W];
        rob_mem_d[tail_q + PW'(i)] = rob_tail_idx + ROB_IDX_W'(i);
      end
    end
    if (flush) begin
      head_d = '0;
      tail_d = '0;
      occ_d  = '0;
    end
  end

  assign occupancy = occ_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  // Entry storage is not reset; occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    uop_mem_q <= uop_mem_d;
    rob_mem_q <= rob_mem_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (free_slots >= CW'(DISP_WIDTH) || nenq == '0);
      assert (occ_q <= CW'(DEPTH));
    end
  end

endmodule
